// File: rtl/box_pkg.sv
// Shared constants, box field layout and FSM states for the box table scheduler.
package box_pkg;

  localparam int BOX_W     = 42;
  localparam int POS_W     = 43;
  localparam int FLAG_BIT  = 42;
  localparam int PTR_W     = 5;

  localparam int XMIN_LSB  = 0;
  localparam int XMIN_W    = 11;
  localparam int YMIN_LSB  = 11;
  localparam int YMIN_W    = 10;
  localparam int XMAX_LSB  = 21;
  localparam int XMAX_W    = 11;
  localparam int YMAX_LSB  = 32;
  localparam int YMAX_W    = 10;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SWAP    = 2'd1,
    ST_CLEAR   = 2'd2
  } state_e;

  // A box is usable when its corners are ordered and it lies inside the frame.
  function automatic logic box_in_range(input logic [BOX_W-1:0] box,
                                        input int unsigned h_pixel,
                                        input int unsigned v_pixel);
    logic [XMIN_W-1:0] xmin;
    logic [XMAX_W-1:0] xmax;
    logic [YMIN_W-1:0] ymin;
    logic [YMAX_W-1:0] ymax;
    xmin = box[XMIN_LSB +: XMIN_W];
    xmax = box[XMAX_LSB +: XMAX_W];
    ymin = box[YMIN_LSB +: YMIN_W];
    ymax = box[YMAX_LSB +: YMAX_W];
    return (xmin <= xmax) && (ymin <= ymax) &&
           (32'(xmax) < h_pixel) && (32'(ymax) < v_pixel);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the channel just served drops to lowest priority.
module rr_arbiter2 (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [1:0] req,
  input  logic       hs,
  output logic [1:0] grant
);

  // Channel currently holding highest priority.
  logic prio_q;
  logic prio_d;

  // Grant selection and priority rotation after a completed handshake.
  always_comb begin
    grant  = req;
    if (req == 2'b11) begin
      grant = prio_q ? 2'b10 : 2'b01;
    end
    prio_d = prio_q;
    if (hs) begin
      prio_d = grant[0];
    end
  end

  // Priority register, channel 0 preferred out of reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/box_table_scheduler.sv
// Collects detector boxes into a shadow table during a frame and publishes
// them to the active table at each frame boundary.
//
//   state      | meaning
//   COLLECT    | accepting boxes, watching pre_vs for a rising edge
//   SWAP       | shadow copied to active on exit
//   CLEAR      | shadow flags and write pointer cleared on exit
module box_table_scheduler
  import box_pkg::*;
#(
  parameter int unsigned H_PIXEL = 1024,
  parameter int unsigned V_PIXEL = 768,
  parameter int unsigned SLOTS   = 16
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        pre_vs,
  input  logic [1:0]                  req_valid,
  input  logic [1:0][BOX_W-1:0]       req_box,
  output logic [1:0]                  req_ready,
  output logic [SLOTS-1:0][POS_W-1:0] pos_data,
  output logic [4:0]                  obj_num,
  output logic [7:0]                  drop_cnt,
  output logic                        swap_pulse
);

  state_e                      state_q, state_d;
  logic                        pre_vs_q;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [SLOTS-1:0][POS_W-1:0] shadow_q, shadow_d;
  logic [SLOTS-1:0][POS_W-1:0] active_q, active_d;
  logic [4:0]                  obj_num_q, obj_num_d;
  logic [7:0]                  drop_cnt_q, drop_cnt_d;
  logic                        swap_pulse_q, swap_pulse_d;

  logic             collect;
  logic             boundary;
  logic [1:0]       arb_req;
  logic [1:0]       grant;
  logic             hs;
  logic [BOX_W-1:0] hs_box;

  assign collect   = (state_q == ST_COLLECT);
  assign boundary  = collect && pre_vs && !pre_vs_q;
  assign arb_req   = collect ? req_valid : 2'b00;
  assign req_ready = grant;
  assign hs        = |(req_valid & grant);
  assign hs_box    = grant[1] ? req_box[1] : req_box[0];

  rr_arbiter2 u_arb (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .req      (arb_req),
    .hs       (hs),
    .grant    (grant)
  );

  // Frame sequencing: a boundary in COLLECT triggers one SWAP and one CLEAR cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (boundary) state_d = ST_SWAP;
      ST_SWAP:    state_d = ST_CLEAR;
      ST_CLEAR:   state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  // Box capture or drop, table publication and shadow clearing.
  always_comb begin
    shadow_d     = shadow_q;
    wr_ptr_d     = wr_ptr_q;
    active_d     = active_q;
    obj_num_d    = obj_num_q;
    drop_cnt_d   = drop_cnt_q;
    swap_pulse_d = 1'b0;

    if (hs) begin
      if (box_in_range(hs_box, H_PIXEL, V_PIXEL) && (32'(wr_ptr_q) < SLOTS)) begin
        shadow_d[wr_ptr_q[3:0]] = {1'b1, hs_box};
        wr_ptr_d                = wr_ptr_q + 5'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end

    if (state_q == ST_SWAP) begin
      active_d     = shadow_q;
      obj_num_d    = wr_ptr_q;
      swap_pulse_d = 1'b1;
    end

    // Only the flags are cleared; stale box bits stay but are marked invalid.
    if (state_q == ST_CLEAR) begin
      for (int i = 0; i < int'(SLOTS); i++) begin
        shadow_d[i][FLAG_BIT] = 1'b0;
      end
      wr_ptr_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_COLLECT;
      pre_vs_q     <= 1'b0;
      wr_ptr_q     <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      obj_num_q    <= '0;
      drop_cnt_q   <= '0;
      swap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_vs_q     <= pre_vs;
      wr_ptr_q     <= wr_ptr_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      obj_num_q    <= obj_num_d;
      drop_cnt_q   <= drop_cnt_d;
      swap_pulse_q <= swap_pulse_d;
    end
  end

  assign pos_data   = active_q;
  assign obj_num    = obj_num_q;
  assign drop_cnt   = drop_cnt_q;
  assign swap_pulse = swap_pulse_q;

endmodule

// File: tb/tb_box_table_scheduler.sv
// Scoreboard bench for box_table_scheduler: a frame-level reference model
// predicts each published table; a monitor checks it when swap_pulse fires.
module tb_box_table_scheduler;

  localparam int H = 1024;
  localparam int V = 768;

  logic                  sys_clk = 1'b0;
  logic                  sys_rst_n;
  logic                  pre_vs;
  logic [1:0]            req_valid;
  logic [1:0][41:0]      req_box;
  logic [1:0]            req_ready;
  logic [15:0][42:0]     pos_data;
  logic [4:0]            obj_num;
  logic [7:0]            drop_cnt;
  logic                  swap_pulse;

  box_table_scheduler dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pre_vs    (pre_vs),
    .req_valid (req_valid),
    .req_box   (req_box),
    .req_ready (req_ready),
    .pos_data  (pos_data),
    .obj_num   (obj_num),
    .drop_cnt  (drop_cnt),
    .swap_pulse(swap_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0][42:0] tbl;
    int                num;
    int                drops;
  } frame_t;

  frame_t exp_q[$];

  // Reference model: frame phase, last served channel, collected boxes.
  logic [15:0][42:0] m_shadow;
  int   m_cnt, m_drops, m_phase, m_last, m_pushes;
  logic m_prev_vs;
  int   n_pulse = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_tbl(input string name, input logic [15:0][42:0] act,
                         input logic [15:0][42:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < 16; i++) begin
        if (act[i] !== exp[i]) begin
          $display("FAIL %s slot %0d: got %h expected %h", name, i, act[i], exp[i]);
          break;
        end
      end
    end
  endtask

  function automatic logic [41:0] mk(input int xmin, input int ymin, input int xmax, input int ymax);
    logic [9:0]  ya, yb;
    logic [10:0] xa, xb;
    xa = 11'(xmin); xb = 11'(xmax); ya = 10'(ymin); yb = 10'(ymax);
    return {yb, xb, ya, xa};
  endfunction

  function automatic logic [41:0] rnd_good();
    int x0, x1, y0, y1;
    x0 = $urandom_range(0, 1000); x1 = $urandom_range(x0, H - 1);
    y0 = $urandom_range(0, 700);  y1 = $urandom_range(y0, V - 1);
    return mk(x0, y0, x1, y1);
  endfunction

  function automatic logic [41:0] rnd_any();
    logic [63:0] r;
    if ($urandom_range(0, 3) != 0) return rnd_good();
    r = {$urandom, $urandom};
    return r[41:0];
  endfunction

  function automatic logic box_ok(input logic [41:0] b);
    int xmin, ymin, xmax, ymax;
    xmin = int'(b[10:0]); ymin = int'(b[20:11]);
    xmax = int'(b[31:21]); ymax = int'(b[41:32]);
    return xmin <= xmax && ymin <= ymax && xmax < H && ymax < V;
  endfunction

  task automatic model_reset();
    m_shadow  = '0;
    m_cnt     = 0;
    m_drops   = 0;
    m_phase   = 0;
    m_last    = 1;
    m_prev_vs = 1'b0;
    exp_q.delete();
  endtask

  // One clock of stimulus; called just after a falling edge, returns at the next one.
  task automatic step(input logic vs, input logic [1:0] v, input logic [41:0] b0, input logic [41:0] b1);
    logic [1:0]  er;
    logic [41:0] bx;
    int          ch;
    frame_t      f;
    pre_vs = vs; req_valid = v; req_box[0] = b0; req_box[1] = b1;
    #1;
    er = 2'b00; ch = -1;
    if (m_phase == 0) begin
      if (v == 2'b11)  ch = 1 - m_last;
      else if (v[0])   ch = 0;
      else if (v[1])   ch = 1;
    end
    if (ch >= 0) er[ch] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    @(posedge sys_clk);
    if (ch >= 0) begin
      m_last = ch;
      bx = (ch == 1) ? b1 : b0;
      if (box_ok(bx) && m_cnt < 16) begin
        m_shadow[m_cnt] = {1'b1, bx};
        m_cnt++;
      end else if (m_drops < 255) begin
        m_drops++;
      end
    end
    case (m_phase)
      0: if (vs && !m_prev_vs) m_phase = 1;
      1: begin
        f.tbl = m_shadow; f.num = m_cnt; f.drops = m_drops;
        exp_q.push_back(f);
        m_pushes++;
        m_phase = 2;
      end
      default: begin
        for (int i = 0; i < 16; i++) m_shadow[i][42] = 1'b0;
        m_cnt   = 0;
        m_phase = 0;
      end
    endcase
    m_prev_vs = vs;
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n, input logic vs);
    repeat (n) step(vs, 2'b00, '0, '0);
  endtask

  task automatic pulse_vs();
    step(1'b1, 2'b00, '0, '0);
    idle(3, 1'b1);
    step(1'b0, 2'b00, '0, '0);
  endtask

  task automatic do_reset();
    #2;
    sys_rst_n = 1'b0;
    pre_vs = 1'b0; req_valid = 2'b00; req_box = '0;
    model_reset();
    #1;
    chk("rst_obj_num", 64'(obj_num), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_swap_pulse", 64'(swap_pulse), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk_tbl("rst_pos_data", pos_data, '0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  // Monitor: pops the expected table on each swap_pulse, checks stability otherwise.
  logic [15:0][42:0] cur_tbl;
  int                cur_num;
  always @(negedge sys_clk) begin
    frame_t f;
    if (!sys_rst_n) begin
      cur_tbl = '0;
      cur_num = 0;
    end else begin
      if (swap_pulse) begin
        n_pulse++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL swap_pulse: got unexpected pulse expected none");
        end else begin
          f = exp_q.pop_front();
          cur_tbl = f.tbl;
          cur_num = f.num;
          chk("drop_cnt_at_swap", 64'(drop_cnt), 64'(f.drops));
        end
      end
      chk("obj_num", 64'(obj_num), 64'(cur_num));
      chk_tbl("pos_data", pos_data, cur_tbl);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [41:0] a[6];
    logic [41:0] b[6];
    logic [41:0] g[3];
    logic        vs;
    m_pushes = 0;
    sys_rst_n = 1'b0;
    pre_vs = 1'b0; req_valid = 2'b00; req_box = '0;
    model_reset();
    #3;
    chk("init_obj_num", 64'(obj_num), 64'd0);
    chk("init_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("init_swap_pulse", 64'(swap_pulse), 64'd0);
    chk_tbl("init_pos_data", pos_data, '0);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Three boxes on channel 0, then a frame boundary.
    for (int i = 0; i < 3; i++) begin
      g[i] = rnd_good();
      step(1'b0, 2'b01, g[i], '0);
    end
    pulse_vs();
    chk("s1_obj_num", 64'(obj_num), 64'd3);
    for (int i = 0; i < 3; i++) chk("s1_slot", 64'(pos_data[i]), 64'({1'b1, g[i]}));
    for (int i = 3; i < 16; i++) chk("s1_empty_slot", 64'(pos_data[i]), 64'd0);
    chk("s1_pulses", 64'(n_pulse), 64'd1);

    // Both channels valid for six cycles: grants alternate starting at channel 0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      a[i] = rnd_good(); b[i] = rnd_good();
      step(1'b0, 2'b11, a[i], b[i]);
    end
    pulse_vs();
    chk("s2_obj_num", 64'(obj_num), 64'd6);
    for (int i = 0; i < 6; i++)
      chk("s2_rr_order", 64'(pos_data[i]), 64'({1'b1, (i % 2 == 0) ? a[i] : b[i]}));

    // Overflow: 18 boxes in one frame, then an inverted-x box.
    for (int i = 0; i < 18; i++) step(1'b0, 2'b10, '0, rnd_good());
    pulse_vs();
    chk("s3_obj_num_full", 64'(obj_num), 64'd16);
    chk("s3_drop_full", 64'(drop_cnt), 64'd2);
    step(1'b0, 2'b01, mk(100, 10, 50, 20), '0);
    chk("s3_drop_bad_x", 64'(drop_cnt), 64'd3);

    // Handshake on the boundary cycle; requests during SWAP/CLEAR; edge in CLEAR ignored.
    g[0] = rnd_good(); g[1] = rnd_good();
    step(1'b0, 2'b01, g[0], '0);
    step(1'b1, 2'b10, '0, g[1]);
    step(1'b0, 2'b11, rnd_good(), rnd_good());
    step(1'b1, 2'b11, rnd_good(), rnd_good());
    idle(4, 1'b1);
    step(1'b0, 2'b00, '0, '0);
    chk("s4_obj_num", 64'(obj_num), 64'd2);
    chk("s4_edge_box", 64'(pos_data[1]), 64'({1'b1, g[1]}));
    chk("s4_pulses", 64'(n_pulse), 64'(m_pushes));

    // Five-box frame followed by an empty frame.
    for (int i = 0; i < 5; i++) step(1'b0, 2'b01, rnd_good(), '0);
    pulse_vs();
    chk("s5_obj_num_5", 64'(obj_num), 64'd5);
    pulse_vs();
    chk("s5_obj_num_0", 64'(obj_num), 64'd0);
    for (int i = 0; i < 16; i++) chk("s5_flag", 64'(pos_data[i][42]), 64'd0);

    // Reset in the middle of collection discards the partial frame.
    step(1'b0, 2'b01, rnd_good(), '0);
    step(1'b0, 2'b10, '0, rnd_good());
    do_reset();
    idle(6, 1'b0);
    chk("s5_no_swap_after_rst", 64'(n_pulse), 64'(m_pushes));
    pulse_vs();
    chk("s5_obj_after_rst", 64'(obj_num), 64'd0);
    chk_tbl("s5_tbl_after_rst", pos_data, '0);

    // Randomized traffic with occasional frame boundaries.
    vs = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) vs = ~vs;
      step(vs, 2'($urandom_range(0, 3)), rnd_any(), rnd_any());
    end
    idle(2, 1'b0);
    pulse_vs();
    idle(3, 1'b0);

    chk("pending_swaps", 64'(exp_q.size()), 64'd0);
    chk("total_pulses", 64'(n_pulse), 64'(m_pushes));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/box_table_scheduler.md
BOX_TABLE_SCHEDULER -- requirements
Module: box_table_scheduler

Interface
REQ-001 SHALL have parameter H_PIXEL, default 1024, meaning active frame width used for box range checks.
REQ-002 SHALL have parameter V_PIXEL, default 768, meaning active frame height used for box range checks.
REQ-003 SHALL have parameter SLOTS, default 16, meaning box table depth; only 16 is supported.
REQ-004 SHALL have port sys_clk  in  1  system clock; all logic is on its rising edge.
REQ-005 SHALL have port sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pre_vs  in  1  frame sync of the fusion datapath; a rising edge marks a frame boundary.
REQ-007 SHALL have port req_valid  in  2  per-requester box-write valid (detector channels 0/1).
REQ-008 SHALL have port req_box  in  2x42  per-requester box: [41:32] ymax, [31:21] xmax, [20:11] ymin, [10:0] xmin.
REQ-009 SHALL have port req_ready  out  2  per-requester ready; a handshake is valid&ready on a rising edge.
REQ-010 SHALL have port pos_data  out  16x43  active table: bit 42 slot-valid flag, bits [41:0] box in req_box format.
REQ-011 SHALL have port obj_num  out  5  number of valid slots in the active table (0..16).
REQ-012 SHALL have port drop_cnt  out  8  saturating count of discarded boxes since reset.
REQ-013 SHALL have port swap_pulse  out  1  one-cycle strobe: active table has just been updated.

Function
REQ-014 SHALL hold two 16-slot tables: shadow (written during collection) and active (drives pos_data, stable for a whole frame).
REQ-015 SHALL run FSM COLLECT -> SWAP -> CLEAR -> COLLECT, each of SWAP and CLEAR lasting exactly one cycle.
REQ-016 SHALL detect a frame boundary as pre_vs=1 while its registered copy is 0, only in COLLECT; edges seen in SWAP/CLEAR are ignored.
REQ-017 SHALL move COLLECT -> SWAP on the edge following boundary detection.
REQ-018 SHALL arbitrate the two requesters round-robin, granting at most one handshake per cycle; after a grant to channel n, channel n has lowest priority.
REQ-019 SHALL assert req_ready[n] combinationally only when state is COLLECT and channel n holds the grant; req_ready is 0 in SWAP and CLEAR.
REQ-020 SHALL, on handshake, write the box into shadow slot wr_ptr with flag 1 and increment 5-bit wr_ptr, when the box passes checks and wr_ptr<16.
REQ-021 SHALL discard the box and increment drop_cnt (saturate at 255) when xmin>xmax, ymin>ymax, xmax>=H_PIXEL, ymax>=V_PIXEL, or wr_ptr==16; no backpressure for full.
REQ-022 SHALL, when a handshake and a boundary detection occur in the same cycle, store the box in the current frame's shadow.
REQ-023 SHALL, on the edge leaving SWAP, copy all shadow slots into active, load obj_num with wr_ptr, and assert swap_pulse for the following cycle only.
REQ-024 SHALL, on the edge leaving CLEAR, zero all shadow flag bits and wr_ptr.
REQ-025 SHALL leave active table and obj_num unchanged between swaps; a frame with zero boxes produces obj_num=0 and all flags 0.

Reset
REQ-026 SHALL on sys_rst_n low clear both tables to 0, wr_ptr 0, obj_num 0, drop_cnt 0, swap_pulse 0, req_ready 0, arbiter priority to channel 0, pre_vs register 0, state COLLECT.
REQ-027 SHALL discard any partially collected frame on reset mid-operation; no swap occurs until the next detected boundary.

Structure
REQ-028 SHALL place BOX_W=42, POS_W=43, field offset constants and the FSM state enum in shared package box_pkg.
REQ-029 SHALL implement arbitration in sub-module rr_arbiter2 (req[1:0], grant[1:0], priority update on handshake).

Verification
REQ-030 Reset, then 3 valid boxes on ch0, pre_vs rise -> swap_pulse once, obj_num=3, pos_data[0..2] flag 1 with exact boxes, slots 3..15 zero.
REQ-031 Both channels valid every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1; slots hold boxes in that order.
REQ-032 18 valid boxes in one frame -> obj_num=16 after swap, drop_cnt=2; box with xmin=100,xmax=50 -> dropped, drop_cnt+1.
REQ-033 Handshake in the cycle pre_vs rises -> box appears in next active table; req_ready=0 during SWAP and CLEAR; second pre_vs rise during SWAP ignored.
REQ-034 Frame with no boxes after a 5-box frame -> obj_num 5->0, all flags 0; reset asserted mid-collection -> all outputs 0, no swap_pulse until next pre_vs rise.
